notch_bank_mc: RTL and testbench

Multi-channel, time-multiplexed second-order IIR notch filter bank. It is the parametrised successor of the single-channel fixed-coefficient notch wrapper. CHANNELS independent audio channels share one multiplier. Each channel has its own runtime-loadable coefficient set, bypass control, output saturation and overrun reporting. It sits between the sample-rate ADC capture and the adaptation/output stages, driven by the same per-sample trigger.

---
 rtl/notch_bank_mc.sv | 210 +++++++++++++++++++++
 tb/tb_notch_bank_mc.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/notch_bank_mc.sv
// Multi-channel time-multiplexed second-order IIR notch filter bank.
// One multiplier is shared by all channels; each channel keeps its own coefficients and history.
module notch_bank_mc #(
    parameter int DATA_SIZE = 24,
    parameter int COEF_SIZE = 35,
    parameter int CHANNELS  = 4,
    parameter logic [COEF_SIZE-1:0] A_INIT  = 35'd17044400784,
    parameter logic [COEF_SIZE-1:0] RA_INIT = 35'd17010311982,
    parameter logic [COEF_SIZE-1:0] R2_INIT = 35'd8555609213
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sample,
    input  logic [CHANNELS*DATA_SIZE-1:0]     data_in,
    input  logic [CHANNELS-1:0]               bypass,
    input  logic                              coef_we,
    input  logic [$clog2(CHANNELS)-1:0]       coef_ch,
    input  logic [1:0]                        coef_sel,
    input  logic [COEF_SIZE-1:0]              coef_data,
    output logic [CHANNELS*DATA_SIZE-1:0]     data_out,
    output logic                              filter_done,
    output logic                              busy,
    output logic                              overflow,
    output logic                              overrun
);

    localparam int FRAC  = COEF_SIZE - 2;
    localparam int ACC_W = DATA_SIZE + COEF_SIZE + 3;
    localparam int CH_W  = $clog2(CHANNELS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_M1   = 3'd2;
    localparam logic [2:0] S_M2   = 3'd3;
    localparam logic [2:0] S_M3   = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic [2:0]                  r_state;
    logic [CH_W-1:0]             r_ch;
    logic signed [DATA_SIZE-1:0] r_xin [CHANNELS];
    logic [CHANNELS-1:0]         r_byp;
    logic signed [DATA_SIZE-1:0] r_x1  [CHANNELS];
    logic signed [DATA_SIZE-1:0] r_x2  [CHANNELS];
    logic signed [DATA_SIZE-1:0] r_y1  [CHANNELS];
    logic signed [DATA_SIZE-1:0] r_y2  [CHANNELS];
    logic signed [DATA_SIZE-1:0] r_res [CHANNELS];
    logic signed [COEF_SIZE-1:0] r_a   [CHANNELS];
    logic signed [COEF_SIZE-1:0] r_ra  [CHANNELS];
    logic signed [COEF_SIZE-1:0] r_r2  [CHANNELS];
    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_satAny;
    logic [CHANNELS*DATA_SIZE-1:0] r_dout;
    logic                        r_done;
    logic                        r_ovf;

    logic signed [COEF_SIZE-1:0]           w_coef;
    logic signed [DATA_SIZE-1:0]           w_opnd;
    logic signed [COEF_SIZE+DATA_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]               w_prodExt;
    logic signed [ACC_W-1:0]               w_xSum;
    logic signed [ACC_W-1:0]               w_rnd;
    logic signed [ACC_W-1:0]               w_shift;
    logic signed [DATA_SIZE-1:0]           w_y;
    logic                                  w_sat;
    logic [CHANNELS*DATA_SIZE-1:0]         w_bank;
    logic                                  w_busy;

    // Steer the shared multiplier to the coefficient/history pair of the current MAC step.
    always_comb begin
        w_coef = r_a[r_ch];
        w_opnd = r_x1[r_ch];
        case (r_state)
            S_M2: begin
                w_coef = r_ra[r_ch];
                w_opnd = r_y1[r_ch];
            end
            S_M3: begin
                w_coef = r_r2[r_ch];
                w_opnd = r_y2[r_ch];
            end
            default: ;
        endcase
    end

    assign w_prod    = w_coef * w_opnd;
    assign w_prodExt = ACC_W'(w_prod);
    assign w_xSum    = (ACC_W'(r_xin[r_ch]) + ACC_W'(r_x2[r_ch])) <<< FRAC;
    assign w_rnd     = r_acc + RND;
    assign w_shift   = w_rnd >>> FRAC;

    always_comb begin
        w_sat = 1'b0;
        w_y   = w_shift[DATA_SIZE-1:0];
        if (r_byp[r_ch]) begin
            w_y = r_xin[r_ch];
        end else if (w_shift > Y_MAX) begin
            w_y   = Y_MAX[DATA_SIZE-1:0];
            w_sat = 1'b1;
        end else if (w_shift < Y_MIN) begin
            w_y   = Y_MIN[DATA_SIZE-1:0];
            w_sat = 1'b1;
        end
    end

    // Result bank with the channel being finished merged in, so the last OUT can publish in one step.
    always_comb begin
        w_bank = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_bank[k*DATA_SIZE +: DATA_SIZE] = (CH_W'(k) == r_ch) ? w_y : r_res[k];
        end
    end

    assign w_busy = (r_state != S_IDLE);

    // data_out/filter_done/overflow are registered on entry to DONE so they are visible during DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_byp    <= '0;
            r_acc    <= '0;
            r_satAny <= 1'b0;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_xin[k] <= '0;
                r_x1[k]  <= '0;
                r_x2[k]  <= '0;
                r_y1[k]  <= '0;
                r_y2[k]  <= '0;
                r_res[k] <= '0;
                r_a[k]   <= A_INIT;
                r_ra[k]  <= RA_INIT;
                r_r2[k]  <= R2_INIT;
            end
        end else begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            r_xin[k] <= data_in[k*DATA_SIZE +: DATA_SIZE];
                        end
                        r_byp   <= bypass;
                        r_ch    <= '0;
                        r_state <= S_LOAD;
                    end else if (coef_we) begin
                        case (coef_sel)
                            2'd0:    r_a[coef_ch]  <= coef_data;
                            2'd1:    r_ra[coef_ch] <= coef_data;
                            2'd2:    r_r2[coef_ch] <= coef_data;
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    r_acc   <= w_xSum;
                    r_state <= S_M1;
                end
                S_M1: begin
                    r_acc   <= r_acc - w_prodExt;
                    r_state <= S_M2;
                end
                S_M2: begin
                    r_acc   <= r_acc + w_prodExt;
                    r_state <= S_M3;
                end
                S_M3: begin
                    r_acc   <= r_acc - w_prodExt;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_x2[r_ch]  <= r_x1[r_ch];
                    r_x1[r_ch]  <= r_xin[r_ch];
                    r_y2[r_ch]  <= r_y1[r_ch];
                    r_y1[r_ch]  <= w_y;
                    r_res[r_ch] <= w_y;
                    r_satAny    <= r_satAny | w_sat;
                    if (r_ch == LAST_CH) begin
                        r_dout   <= w_bank;
                        r_done   <= 1'b1;
                        r_ovf    <= r_satAny | w_sat;
                        r_satAny <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out    = r_dout;
    assign filter_done = r_done;
    assign overflow    = r_ovf;
    assign busy        = w_busy;
    assign overrun     = sample & w_busy;

endmodule

// File: tb/tb_notch_bank_mc.sv
// Self-checking bench for notch_bank_mc: randomized samples compared against an arithmetic
// model of the notch difference equation kept per channel.
module tb_notch_bank_mc;

    localparam int DW   = 24;
    localparam int CW   = 35;
    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int FRAC = 33;
    localparam longint MAXV = 8388607;
    localparam longint MINV = -8388608;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              sample;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]    bypass;
    logic              coef_we;
    logic [CHW-1:0]    coef_ch;
    logic [1:0]        coef_sel;
    logic [CW-1:0]     coef_data;
    logic [NCH*DW-1:0] data_out;
    logic              filter_done;
    logic              busy;
    logic              overflow;
    logic              overrun;

    int nCompared   = 0;
    int nMismatched = 0;

    longint mA [NCH], mRA [NCH], mR2 [NCH];
    longint mx1[NCH], mx2[NCH], my1[NCH], my2[NCH];
    longint expY[NCH];
    logic   expOvf;

    notch_bank_mc dut (
        .clk(clk), .reset(reset), .sample(sample), .data_in(data_in), .bypass(bypass),
        .coef_we(coef_we), .coef_ch(coef_ch), .coef_sel(coef_sel), .coef_data(coef_data),
        .data_out(data_out), .filter_done(filter_done), .busy(busy),
        .overflow(overflow), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < NCH; k++) begin
            mA[k]  = 64'sd17044400784;
            mRA[k] = 64'sd17010311982;
            mR2[k] = 64'sd8555609213;
            mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; expY[k] = 0;
        end
        expOvf = 1'b0;
    endtask

    // y = x - A*x1 + x2 + RA*y1 - R2*y2 evaluated in plain 64-bit arithmetic, rounded and clipped.
    task automatic modelSample(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] b);
        longint x, acc, y;
        expOvf = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            x = longint'($signed(d[k*DW +: DW]));
            if (b[k]) begin
                y = x;
            end else begin
                acc = (x + mx2[k]) * (longint'(1) << FRAC) - mA[k] * mx1[k]
                      + mRA[k] * my1[k] - mR2[k] * my2[k];
                y = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
                if (y > MAXV) begin y = MAXV; expOvf = 1'b1; end
                else if (y < MINV) begin y = MINV; expOvf = 1'b1; end
            end
            mx2[k] = mx1[k]; mx1[k] = x;
            my2[k] = my1[k]; my1[k] = y;
            expY[k] = y;
        end
    endtask

    task automatic applyReset();
        sample = 0; coef_we = 0; data_in = '0; bypass = '0;
        coef_ch = '0; coef_sel = '0; coef_data = '0;
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        modelReset();
    endtask

    task automatic writeCoef(input int ch, input int sel, input logic [CW-1:0] val);
        coef_we = 1; coef_ch = CHW'(ch); coef_sel = 2'(sel); coef_data = val;
        tick();
        coef_we = 0;
        if (sel == 0) mA[ch] = longint'($signed(val));
        else if (sel == 1) mRA[ch] = longint'($signed(val));
        else if (sel == 2) mR2[ch] = longint'($signed(val));
    endtask

    function automatic logic [NCH*DW-1:0] randBank();
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Fires one sample and waits (bounded) for filter_done; optionally tries a write that must be dropped.
    task automatic runSample(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] b,
                             input bit busyWr, input bit sameWr,
                             output int lat, output logic ovf);
        data_in = d; bypass = b; sample = 1;
        if (sameWr) begin
            coef_we = 1; coef_ch = 2'd2; coef_sel = 2'd0; coef_data = 35'h1_0000_0000;
        end
        tick();
        sample = 0; coef_we = 0; lat = 1;
        while (!filter_done && lat < 60) begin
            if (busyWr && lat == 5) begin
                coef_we = 1; coef_ch = 2'd2; coef_sel = 2'd0; coef_data = 35'h1_0000_0000;
            end else begin
                coef_we = 0;
            end
            tick();
            lat++;
        end
        coef_we = 0;
        ovf = overflow;
        tick();
    endtask

    task automatic test_reset();
        longint got;
        int lat;
        logic ovf;
        logic [NCH*DW-1:0] d;
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            sample = 1'($urandom); coef_we = 1'($urandom); data_in = randBank();
            bypass = NCH'($urandom); coef_ch = CHW'($urandom); coef_sel = 2'($urandom);
            coef_data = CW'({$urandom, $urandom});
            tick();
            nCompared++;
            if ({data_out, filter_done, busy, overflow, overrun} !== '0) begin
                nMismatched++;
                $display("[TB] FAIL reset_outputs: got dout=%h done=%b busy=%b ovf=%b ovr=%b, need all 0",
                         data_out, filter_done, busy, overflow, overrun);
            end
        end
        sample = 0; coef_we = 0; bypass = '0;
        reset = 1;
        tick();
        modelReset();
        d = randBank();
        modelSample(d, '0);
        runSample(d, '0, 0, 0, lat, ovf);
        for (int k = 0; k < NCH; k++) begin
            got = longint'($signed(data_out[k*DW +: DW]));
            nCompared++;
            if (got !== expY[k]) begin
                nMismatched++;
                $display("[TB] FAIL reset_defaults ch%0d: got %0d, need %0d", k, got, expY[k]);
            end
        end
    endtask

    task automatic test_impulse();
        longint imp[3] = '{1000, -4, -4};
        longint got;
        int lat;
        logic ovf;
        logic [NCH*DW-1:0] d;
        applyReset();
        for (int s = 0; s < 3; s++) begin
            d = '0;
            if (s == 0) d[0 +: DW] = 24'd1000;
            modelSample(d, '0);
            runSample(d, '0, 0, 0, lat, ovf);
            nCompared++;
            if (lat !== 21) begin
                nMismatched++;
                $display("[TB] FAIL impulse_latency s%0d: got %0d, need 21", s, lat);
            end
            got = longint'($signed(data_out[0 +: DW]));
            nCompared++;
            if (got !== imp[s]) begin
                nMismatched++;
                $display("[TB] FAIL impulse_ch0 s%0d: got %0d, need %0d", s, got, imp[s]);
            end
            for (int k = 1; k < NCH; k++) begin
                got = longint'($signed(data_out[k*DW +: DW]));
                nCompared++;
                if (got !== expY[k]) begin
                    nMismatched++;
                    $display("[TB] FAIL impulse_other ch%0d s%0d: got %0d, need %0d", k, s, got, expY[k]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        longint got;
        int lat;
        logic ovf;
        logic [NCH*DW-1:0] d;
        applyReset();
        d = randBank();
        d[DW +: DW] = 24'(-12345);
        modelSample(d, 4'b0010);
        runSample(d, 4'b0010, 0, 0, lat, ovf);
        got = longint'($signed(data_out[DW +: DW]));
        nCompared++;
        if (got !== -64'sd12345) begin
            nMismatched++;
            $display("[TB] FAIL bypass_ch1: got %0d, need -12345", got);
        end
        d = '0;
        modelSample(d, '0);
        runSample(d, '0, 0, 0, lat, ovf);
        for (int k = 0; k < NCH; k++) begin
            got = longint'($signed(data_out[k*DW +: DW]));
            nCompared++;
            if (got !== expY[k]) begin
                nMismatched++;
                $display("[TB] FAIL bypass_history ch%0d: got %0d, need %0d", k, got, expY[k]);
            end
        end
    endtask

    task automatic test_coef_write();
        logic expO[3] = '{1'b0, 1'b0, 1'b1};
        longint got;
        int lat;
        logic ovf;
        logic [NCH*DW-1:0] d;
        applyReset();
        writeCoef(2, 0, '0);
        writeCoef(2, 1, '0);
        writeCoef(2, 2, '0);
        writeCoef(2, 3, 35'h7_1234_5678);
        for (int s = 0; s < 3; s++) begin
            d = '0;
            d[2*DW +: DW] = 24'd8388607;
            modelSample(d, '0);
            runSample(d, '0, 0, 0, lat, ovf);
            got = longint'($signed(data_out[2*DW +: DW]));
            nCompared++;
            if (got !== 64'sd8388607) begin
                nMismatched++;
                $display("[TB] FAIL coef_ch2 s%0d: got %0d, need 8388607", s, got);
            end
            nCompared++;
            if (ovf !== expO[s]) begin
                nMismatched++;
                $display("[TB] FAIL coef_overflow s%0d: got %b, need %b", s, ovf, expO[s]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            d = randBank();
            modelSample(d, '0);
            runSample(d, '0, s == 0, s == 1, lat, ovf);
            for (int k = 0; k < NCH; k++) begin
                got = longint'($signed(data_out[k*DW +: DW]));
                nCompared++;
                if (got !== expY[k]) begin
                    nMismatched++;
                    $display("[TB] FAIL coef_dropped_write s%0d ch%0d: got %0d, need %0d", s, k, got, expY[k]);
                end
            end
            nCompared++;
            if (ovf !== expOvf) begin
                nMismatched++;
                $display("[TB] FAIL coef_dropped_ovf s%0d: got %b, need %b", s, ovf, expOvf);
            end
        end
    endtask

    task automatic test_overrun();
        longint got;
        int cyc, nDone, firstDone;
        logic [NCH*DW-1:0] d;
        applyReset();
        d = randBank();
        modelSample(d, '0);
        data_in = d; bypass = '0; sample = 1;
        tick();
        sample = 0;
        for (int i = 0; i < 9; i++) tick();
        data_in = randBank();
        sample = 1;
        #1;
        nCompared++;
        if (overrun !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL overrun_pulse: got %b, need 1", overrun);
        end
        tick();
        sample = 0;
        #1;
        nCompared++;
        if (overrun !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL overrun_clear: got %b, need 0", overrun);
        end
        cyc = 11; nDone = 0; firstDone = -1;
        while (cyc < 70) begin
            if (filter_done) begin
                nDone++;
                if (firstDone < 0) firstDone = cyc;
            end
            tick();
            cyc++;
        end
        nCompared++;
        if (nDone !== 1 || firstDone !== 21) begin
            nMismatched++;
            $display("[TB] FAIL overrun_done: got %0d pulses first at %0d, need 1 at 21", nDone, firstDone);
        end
        for (int k = 0; k < NCH; k++) begin
            got = longint'($signed(data_out[k*DW +: DW]));
            nCompared++;
            if (got !== expY[k]) begin
                nMismatched++;
                $display("[TB] FAIL overrun_result ch%0d: got %0d, need %0d", k, got, expY[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        longint got;
        int lat, nDone;
        logic ovf;
        logic [NCH*DW-1:0] d;
        applyReset();
        d = randBank();
        data_in = d; bypass = '0; sample = 1;
        tick();
        sample = 0;
        for (int i = 0; i < 11; i++) tick();
        reset = 0;
        #1;
        nCompared++;
        if (busy !== 1'b0 || data_out !== '0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_abort: got busy=%b dout=%h, need 0", busy, data_out);
        end
        tick();
        reset = 1;
        nDone = 0;
        for (int i = 0; i < 30; i++) begin
            if (filter_done) nDone++;
            tick();
        end
        nCompared++;
        if (nDone !== 0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_nodone: got %0d pulses, need 0", nDone);
        end
        modelReset();
        modelSample(d, '0);
        runSample(d, '0, 0, 0, lat, ovf);
        for (int k = 0; k < NCH; k++) begin
            got = longint'($signed(data_out[k*DW +: DW]));
            nCompared++;
            if (got !== expY[k]) begin
                nMismatched++;
                $display("[TB] FAIL midreset_rerun ch%0d: got %0d, need %0d", k, got, expY[k]);
            end
        end
    endtask

    task automatic test_random();
        longint got;
        int lat;
        logic ovf;
        logic [NCH*DW-1:0] d;
        logic [NCH-1:0] b;
        applyReset();
        for (int s = 0; s < 10; s++) begin
            if ($urandom_range(0, 1) == 1)
                writeCoef(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
                          CW'({$urandom, $urandom}));
            d = randBank();
            b = NCH'($urandom);
            modelSample(d, b);
            runSample(d, b, 0, 0, lat, ovf);
            nCompared++;
            if (lat !== 21 || ovf !== expOvf) begin
                nMismatched++;
                $display("[TB] FAIL random_ctrl s%0d: got lat=%0d ovf=%b, need 21 %b", s, lat, ovf, expOvf);
            end
            for (int k = 0; k < NCH; k++) begin
                got = longint'($signed(data_out[k*DW +: DW]));
                nCompared++;
                if (got !== expY[k]) begin
                    nMismatched++;
                    $display("[TB] FAIL random_out s%0d ch%0d: got %0d, need %0d", s, k, got, expY[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 0; sample = 0; coef_we = 0; data_in = '0; bypass = '0;
        coef_ch = '0; coef_sel = '0; coef_data = '0;
        modelReset();
        test_reset();
        test_impulse();
        test_bypass();
        test_coef_write();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
